// File: rtl/prog_load_ctrl.sv
// UART program loader: receives a length-prefixed, XOR-checksummed frame
// and writes it into instruction memory while holding the CPU in reset.
// Ports:
//   clk, rstn                  clock, async active-low reset
//   start_load                 request a load (IDLE or ERR only)
//   rx_valid, rx_byte          received UART byte strobe and data
//   cpu_imem_addr              CPU fetch address
//   imem_addr/wdata/we         shared instruction-memory port
//   cpu_rstn                   CPU reset (low while loading)
//   loading                    loader owns instruction memory
//   load_done                  one-cycle success pulse
//   load_err                   sticky error flag
module prog_load_ctrl #(
  parameter int ADDR_W  = 14,
  parameter int TIMEOUT = 100000
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start_load,
  input  logic              rx_valid,
  input  logic [7:0]        rx_byte,
  input  logic [ADDR_W-1:0] cpu_imem_addr,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              imem_we,
  output logic              cpu_rstn,
  output logic              loading,
  output logic              load_done,
  output logic              load_err
);

  localparam int TW = $clog2(TIMEOUT + 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LEN_LO = 3'd1;
  localparam logic [2:0] S_LEN_HI = 3'd2;
  localparam logic [2:0] S_DATA   = 3'd3;
  localparam logic [2:0] S_CHECK  = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;
  localparam logic [2:0] S_ERR    = 3'd6;

  logic [2:0]    state;
  logic [2:0]    nxt;
  logic [15:0]   len;
  logic [15:0]   len_new;
  logic [15:0]   word_idx;
  logic [1:0]    byte_idx;
  logic [7:0]    csum;
  logic [TW-1:0] tcnt;
  logic          tmo;
  logic          len_bad;
  logic          rx_phase;
  logic          go;

  // Frame-receiving states where the inter-byte watchdog runs.
  assign rx_phase = (state == S_LEN_LO) || (state == S_LEN_HI) ||
                    (state == S_DATA)   || (state == S_CHECK);

  assign go = start_load && ((state == S_IDLE) || (state == S_ERR));

  // Fires on the edge where the idle count would reach TIMEOUT.
  assign tmo = rx_phase && !rx_valid &&
               (tcnt == TW'(TIMEOUT - 1));

  assign len_new = {rx_byte, len[7:0]};
  assign len_bad = (len_new == 16'd0) ||
                   (32'(len_new) > (32'd1 << ADDR_W));

  always_comb begin
    nxt = state;
    case (state)
      S_IDLE:   if (start_load) nxt = S_LEN_LO;
      S_LEN_LO: begin
        if (rx_valid)  nxt = S_LEN_HI;
        else if (tmo)  nxt = S_ERR;
      end
      S_LEN_HI: begin
        if (rx_valid)  nxt = len_bad ? S_ERR : S_DATA;
        else if (tmo)  nxt = S_ERR;
      end
      // Last byte of the last word: the write still issues next cycle.
      S_DATA: begin
        if (rx_valid && byte_idx == 2'd3 &&
            word_idx == len - 16'd1)
          nxt = S_CHECK;
        else if (tmo)
          nxt = S_ERR;
      end
      S_CHECK: begin
        if (rx_valid)  nxt = (rx_byte == csum) ? S_DONE : S_ERR;
        else if (tmo)  nxt = S_ERR;
      end
      S_DONE:   nxt = S_IDLE;
      S_ERR:    if (start_load) nxt = S_LEN_LO;
      default:  nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= S_IDLE;
      len        <= '0;
      word_idx   <= '0;
      byte_idx   <= '0;
      csum       <= '0;
      tcnt       <= '0;
      imem_wdata <= '0;
      imem_we    <= 1'b0;
      loading    <= 1'b0;
      load_done  <= 1'b0;
      load_err   <= 1'b0;
    end else begin
      state     <= nxt;
      loading   <= (nxt != S_IDLE);
      load_done <= (nxt == S_DONE);
      load_err  <= (nxt == S_ERR);
      imem_we   <= 1'b0;

      if (imem_we) word_idx <= word_idx + 16'd1;

      if (rx_phase) tcnt <= rx_valid ? '0 : tcnt + TW'(1);
      else          tcnt <= '0;

      if (go) begin
        word_idx <= '0;
        byte_idx <= '0;
        csum     <= '0;
        tcnt     <= '0;
      end

      if (rx_valid) begin
        case (state)
          S_LEN_LO: len[7:0]  <= rx_byte;
          S_LEN_HI: len[15:8] <= rx_byte;
          S_DATA: begin
            imem_wdata[8*byte_idx +: 8] <= rx_byte;
            csum     <= csum ^ rx_byte;
            byte_idx <= byte_idx + 2'd1;
            if (byte_idx == 2'd3) imem_we <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  assign cpu_rstn  = ~loading;
  assign imem_addr = loading ? ADDR_W'(word_idx) : cpu_imem_addr;

endmodule

// File: tb/tb_prog_load_ctrl.sv
// Directed bench for prog_load_ctrl: good/bad frames, length limits,
// inter-byte timeout, mid-load reset and ignored start/rx pulses.
module tb_prog_load_ctrl;

  localparam int AW = 14;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          start_load = 1'b0;
  logic          rx_valid = 1'b0;
  logic [7:0]    rx_byte = '0;
  logic [AW-1:0] cpu_imem_addr = '0;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic          imem_we;
  logic          cpu_rstn;
  logic          loading;
  logic          load_done;
  logic          load_err;

  int total = 0;
  int bad   = 0;

  int          wr_cnt = 0;
  int          done_cnt = 0;
  logic [31:0] wr_addr [4];
  logic [31:0] wr_data [4];

  prog_load_ctrl #(.ADDR_W(AW), .TIMEOUT(16)) dut (
    .clk(clk), .rstn(rstn),
    .start_load(start_load),
    .rx_valid(rx_valid), .rx_byte(rx_byte),
    .cpu_imem_addr(cpu_imem_addr),
    .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .imem_we(imem_we), .cpu_rstn(cpu_rstn),
    .loading(loading), .load_done(load_done),
    .load_err(load_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (imem_we) begin
      if (wr_cnt < 4) begin
        wr_addr[wr_cnt] = 32'(imem_addr);
        wr_data[wr_cnt] = imem_wdata;
      end
      wr_cnt = wr_cnt + 1;
    end
    if (load_done) done_cnt = done_cnt + 1;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total = total + 1;
    assert (obs === exp) else begin
      bad = bad + 1;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_valid = 1'b1;
    rx_byte  = b;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start_load = 1'b1;
    @(negedge clk);
    start_load = 1'b0;
  endtask

  task automatic clr_log();
    wr_cnt   = 0;
    done_cnt = 0;
  endtask

  task automatic send_payload();
    logic [7:0] p [8];
    p = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h6F, 8'h00, 8'h00, 8'h00};
    for (int i = 0; i < 8; i++) send_byte(p[i]);
  endtask

  task automatic check_words(input string tag);
    chk({tag, "_wr_cnt"}, 32'(wr_cnt), 32'd2);
    chk({tag, "_addr0"}, wr_addr[0], 32'd0);
    chk({tag, "_data0"}, wr_data[0], 32'h0000_0013);
    chk({tag, "_addr1"}, wr_addr[1], 32'd1);
    chk({tag, "_data1"}, wr_data[1], 32'h0000_006F);
  endtask

  initial begin
    // Reset state
    cpu_imem_addr = 14'h0005;
    repeat (2) @(negedge clk);
    chk("rst_loading", 32'(loading), 32'd0);
    chk("rst_cpu_rstn", 32'(cpu_rstn), 32'd1);
    chk("rst_we", 32'(imem_we), 32'd0);
    chk("rst_done", 32'(load_done), 32'd0);
    chk("rst_err", 32'(load_err), 32'd0);
    chk("rst_wdata", imem_wdata, 32'd0);
    chk("rst_addr_mux", 32'(imem_addr), 32'h5);
    rstn = 1'b1;
    @(negedge clk);

    // Good two-word load
    clr_log();
    pulse_start();
    chk("good_loading", 32'(loading), 32'd1);
    chk("good_cpu_held", 32'(cpu_rstn), 32'd0);
    send_byte(8'h02);
    send_byte(8'h00);
    send_payload();
    send_byte(8'h7C);
    repeat (3) @(negedge clk);
    check_words("good");
    chk("good_done_cnt", 32'(done_cnt), 32'd1);
    chk("good_cpu_run", 32'(cpu_rstn), 32'd1);
    chk("good_loading_off", 32'(loading), 32'd0);
    chk("good_err", 32'(load_err), 32'd0);
    chk("good_addr_mux", 32'(imem_addr), 32'h5);

    // Bad checksum: words written, then sticky error
    clr_log();
    pulse_start();
    send_byte(8'h02);
    send_byte(8'h00);
    send_payload();
    send_byte(8'h00);
    repeat (3) @(negedge clk);
    check_words("badck");
    chk("badck_err", 32'(load_err), 32'd1);
    chk("badck_cpu_held", 32'(cpu_rstn), 32'd0);
    chk("badck_done_cnt", 32'(done_cnt), 32'd0);
    repeat (30) @(negedge clk);
    chk("badck_err_sticky", 32'(load_err), 32'd1);
    chk("badck_cpu_sticky", 32'(cpu_rstn), 32'd0);

    // Restart from ERR, zero length
    clr_log();
    pulse_start();
    chk("restart_err_clr", 32'(load_err), 32'd0);
    chk("restart_loading", 32'(loading), 32'd1);
    send_byte(8'h00);
    chk("len0_after_lo", 32'(load_err), 32'd0);
    send_byte(8'h00);
    chk("len0_err", 32'(load_err), 32'd1);

    // L = 16385 exceeds a 14-bit memory
    pulse_start();
    send_byte(8'h01);
    send_byte(8'h40);
    chk("len_big_err", 32'(load_err), 32'd1);
    chk("len_no_write", 32'(wr_cnt), 32'd0);

    // Timeout after three payload bytes
    clr_log();
    pulse_start();
    send_byte(8'h01);
    send_byte(8'h00);
    send_byte(8'hAA);
    send_byte(8'hBB);
    send_byte(8'hCC);
    repeat (15) @(negedge clk);
    chk("tmo_not_yet", 32'(load_err), 32'd0);
    @(negedge clk);
    chk("tmo_err", 32'(load_err), 32'd1);
    chk("tmo_no_write", 32'(wr_cnt), 32'd0);

    // Reset mid-DATA, then a clean load
    clr_log();
    pulse_start();
    send_byte(8'h02);
    send_byte(8'h00);
    send_byte(8'h13);
    send_byte(8'h00);
    send_byte(8'h00);
    @(negedge clk);
    cpu_imem_addr = 14'h0123;
    rstn = 1'b0;
    #1;
    chk("mid_rst_loading", 32'(loading), 32'd0);
    chk("mid_rst_cpu", 32'(cpu_rstn), 32'd1);
    chk("mid_rst_err", 32'(load_err), 32'd0);
    chk("mid_rst_wdata", imem_wdata, 32'd0);
    chk("mid_rst_addr", 32'(imem_addr), 32'h123);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    pulse_start();
    send_byte(8'h02);
    send_byte(8'h00);
    send_payload();
    send_byte(8'h7C);
    repeat (3) @(negedge clk);
    check_words("post_rst");
    chk("post_rst_done", 32'(done_cnt), 32'd1);

    // Stray rx in IDLE, start+rx together, start mid-DATA
    clr_log();
    send_byte(8'hAB);
    chk("idle_rx_loading", 32'(loading), 32'd0);
    @(negedge clk);
    start_load = 1'b1;
    rx_valid   = 1'b1;
    rx_byte    = 8'h05;
    @(negedge clk);
    start_load = 1'b0;
    rx_valid   = 1'b0;
    chk("combo_loading", 32'(loading), 32'd1);
    send_byte(8'h02);
    send_byte(8'h00);
    send_byte(8'h13);
    send_byte(8'h00);
    pulse_start();
    send_byte(8'h00);
    send_byte(8'h00);
    send_byte(8'h6F);
    send_byte(8'h00);
    pulse_start();
    send_byte(8'h00);
    send_byte(8'h00);
    send_byte(8'h7C);
    repeat (3) @(negedge clk);
    check_words("noise");
    chk("noise_done", 32'(done_cnt), 32'd1);
    chk("noise_err", 32'(load_err), 32'd0);
    chk("noise_cpu_run", 32'(cpu_rstn), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
